// File: rtl/train_scheduler.sv
// train_scheduler: epoch-level training controller sequencing clear, forward pass,
// backprop and weight commit, with early stop on zero loss and per-phase timeout.
module train_scheduler #(
    parameter int EPOCH_W = 8,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               init_i,
    input  logic [EPOCH_W-1:0] epochs_i,
    input  logic               zero_end_check_i,
    input  logic               f_end_i,
    input  logic               loss_zero_i,
    input  logic               b_end_i,
    output logic               zero_o,
    output logic               f_pass_o,
    output logic               b_pass_o,
    output logic               w_update_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               early_o,
    output logic               timeout_o
);
    typedef enum logic [2:0] {IDLE, CLEAR, FWD, BWD, UPDATE, DONE, ERR} state_t;
    state_t             state, state_nxt;
    logic [EPOCH_W-1:0] target, epoch_inc;
    logic [TO_W-1:0]    cnt;
    logic               init_q, start, in_phase, idle_like, expired;

    assign start     = init_i & ~init_q;
    assign epoch_inc = epoch_o + 1'b1;
    assign in_phase  = (state == CLEAR) | (state == FWD) | (state == BWD);
    assign idle_like = (state == IDLE) | (state == DONE) | (state == ERR);
    // An end handshake on the terminal-count cycle takes priority over the timeout.
    assign expired   = in_phase & (cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: state_nxt = start ? CLEAR : state;
            CLEAR:           state_nxt = zero_end_check_i ? FWD : expired ? ERR : CLEAR;
            FWD:             state_nxt = f_end_i ? (loss_zero_i ? DONE : BWD) : expired ? ERR : FWD;
            BWD:             state_nxt = b_end_i ? UPDATE : expired ? ERR : BWD;
            UPDATE:          state_nxt = (epoch_inc == target) ? DONE : CLEAR;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            epoch_o <= '0;
            target  <= '0;
            early_o <= 1'b0;
            cnt     <= '0;
            init_q  <= 1'b0;
        end else if (en_i) begin
            state  <= state_nxt;
            init_q <= init_i;
            cnt    <= (state_nxt != state) ? '0 : in_phase ? cnt + 1'b1 : cnt;
            if (start && idle_like) begin
                target  <= (epochs_i == '0) ? EPOCH_W'(1) : epochs_i;
                epoch_o <= '0;
                early_o <= 1'b0;
            end
            if (state == UPDATE)
                epoch_o <= epoch_inc;
            if (state == FWD && f_end_i && loss_zero_i)
                early_o <= 1'b1;
        end
    end

    assign zero_o     = state == CLEAR;
    assign f_pass_o   = state == FWD;
    assign b_pass_o   = state == BWD;
    assign w_update_o = (state == UPDATE) & en_i;
    assign busy_o     = in_phase | (state == UPDATE);
    assign done_o     = state == DONE;
    assign timeout_o  = state == ERR;
endmodule

// File: tb/tb_train_scheduler.sv
// tb_train_scheduler: randomized jobs against an epoch-level reference model; a
// monitor pops expected outcomes whenever the scheduler reports done or timeout.
module tb_train_scheduler;
    localparam int EW = 8;
    localparam int TO = 64;

    logic          clk_i = 1'b0, rst_i = 1'b0, en_i = 1'b0, init_i = 1'b0;
    logic          zero_end_check_i = 1'b0, f_end_i = 1'b0, loss_zero_i = 1'b0, b_end_i = 1'b0;
    logic [EW-1:0] epochs_i = '0;
    logic          zero_o, f_pass_o, b_pass_o, w_update_o, busy_o, done_o, early_o, timeout_o;
    logic [EW-1:0] epoch_o;

    int compared = 0, mismatched = 0;
    int edges = 0, ups = 0, cum_ups = 0;
    int dl[3][8];
    int loss_ep = -1;

    typedef struct {
        bit err;
        int epoch;
        bit early;
        int updates;
        int end_edge;
    } exp_t;
    exp_t q[$];

    always #5 clk_i = ~clk_i;

    train_scheduler #(.EPOCH_W(EW), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .init_i(init_i), .epochs_i(epochs_i),
        .zero_end_check_i(zero_end_check_i), .f_end_i(f_end_i), .loss_zero_i(loss_zero_i),
        .b_end_i(b_end_i), .zero_o(zero_o), .f_pass_o(f_pass_o), .b_pass_o(b_pass_o),
        .w_update_o(w_update_o), .epoch_o(epoch_o), .busy_o(busy_o), .done_o(done_o),
        .early_o(early_o), .timeout_o(timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Epoch-level model: each handshake phase lasts delay+1 enabled cycles, a phase
    // whose end never arrives lasts TO cycles, and each commit adds one cycle.
    function automatic exp_t model(input int ep, input int s);
        exp_t r;
        int   n = (ep == 0) ? 1 : ep;
        int   t = 0;
        bit   fin = 1'b0;
        r.err = 1'b0; r.early = 1'b0; r.epoch = n;
        for (int e = 0; e < n && !fin; e++) begin
            for (int p = 0; p < 3 && !fin; p++) begin
                if (dl[p][e] >= TO) begin
                    t += TO; r.err = 1'b1; r.epoch = e; fin = 1'b1;
                end else begin
                    t += dl[p][e] + 1;
                    if (p == 1 && e == loss_ep) begin
                        r.early = 1'b1; r.epoch = e; fin = 1'b1;
                    end
                end
            end
            if (!fin) t += 1;
        end
        r.updates = r.epoch;
        r.end_edge = s + t;
        return r;
    endfunction

    function automatic int pick();
        int r = $urandom_range(0, 59);
        return (r == 0) ? 255 : (r < 3) ? TO - 1 : $urandom_range(0, 4);
    endfunction

    task automatic cfg(input bit rnd);
        for (int p = 0; p < 3; p++)
            for (int e = 0; e < 8; e++)
                dl[p][e] = rnd ? pick() : 0;
    endtask

    task automatic run_job(input int ep, input int lep, input bit gap, input bit enr);
        exp_t e;
        int   ph, prev_ph = -1, pc = 0, idx = -1, gap_cnt = 0, n = 0;
        loss_ep = lep;
        @(negedge clk_i);
        en_i = 1'b1; init_i = 1'b1; epochs_i = EW'(ep);
        @(posedge clk_i);
        #2;
        e = model(ep, edges);
        cum_ups += e.updates;
        e.updates = cum_ups;
        q.push_back(e);
        @(negedge clk_i);
        check("start_clear", zero_o, 1);
        check("start_timeout", timeout_o, 0);
        check("start_done", done_o, 0);
        check("start_epoch", epoch_o, 0);
        check("start_early", early_o, 0);
        forever begin
            ph = zero_o ? 0 : f_pass_o ? 1 : b_pass_o ? 2 : busy_o ? 3 : 4;
            if (ph == 4) break;
            if (ph != prev_ph) begin
                pc = 0;
                if (ph == 0) idx++;
            end else if (en_i) pc++;
            prev_ph = ph;
            init_i = 1'b0;
            zero_end_check_i = (ph == 0) ? (pc == dl[0][idx % 8]) : 1'($urandom);
            f_end_i          = (ph == 1) ? (pc == dl[1][idx % 8]) : 1'($urandom);
            loss_zero_i      = (ph == 1 && pc == dl[1][idx % 8]) ? (idx == loss_ep) : 1'($urandom);
            b_end_i          = (ph == 2) ? (pc == dl[2][idx % 8]) : 1'($urandom);
            if (gap && ph == 3 && gap_cnt < 10) begin
                en_i = 1'b0;
                gap_cnt++;
            end else en_i = enr ? ($urandom_range(0, 4) != 0) : 1'b1;
            // A start edge while busy must be ignored, even with new epochs_i.
            if (ph < 3 && $urandom_range(0, 7) == 0) begin
                init_i = 1'b1;
                epochs_i = EW'($urandom);
            end
            if (++n > 20000) begin
                check("job_finished", ph, 4);
                break;
            end
            @(negedge clk_i);
        end
        init_i = 1'b0; en_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin : monitor
        bit   pd = 1'b0, pt = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                pd = 1'b0; pt = 1'b0;
            end else begin
                if (en_i) edges++;
                if (w_update_o) ups++;
                if (!en_i) check("w_update_gated", w_update_o, 0);
                if ((done_o && !pd) || (timeout_o && !pt)) begin
                    check("end_expected", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("end_cycle", edges, e.end_edge);
                        check("timeout", timeout_o, e.err);
                        check("done", done_o, !e.err);
                        check("epoch", epoch_o, e.epoch);
                        check("early", early_o, e.early);
                        check("updates", ups, e.updates);
                        check("busy_end", busy_o, 0);
                    end
                end
                pd = done_o; pt = timeout_o;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_epoch", epoch_o, 0);
        check("rst_early", early_o, 0);
        check("rst_zero", zero_o, 0);
        check("rst_w_update", w_update_o, 0);
        rst_i = 1'b1; en_i = 1'b1;
        @(negedge clk_i);
        check("idle_busy", busy_o, 0);
        check("idle_done", done_o, 0);

        cfg(0); run_job(3, -1, 0, 0);
        cfg(0); run_job(5, 1, 0, 0);
        cfg(0); dl[2][0] = 255; run_job(2, -1, 0, 0);
        cfg(0); dl[0][0] = TO - 1; dl[1][0] = TO - 1; dl[2][0] = TO - 1; run_job(1, -1, 0, 0);
        cfg(0); run_job(0, -1, 0, 0);
        cfg(0); run_job(3, -1, 1, 0);

        // Asynchronous reset in the middle of backprop.
        @(negedge clk_i);
        epochs_i = 8'd2; init_i = 1'b1; en_i = 1'b1;
        zero_end_check_i = 1'b1; f_end_i = 1'b1; loss_zero_i = 1'b0; b_end_i = 1'b0;
        @(negedge clk_i);
        init_i = 1'b0;
        for (int i = 0; i < 10 && !b_pass_o; i++) @(negedge clk_i);
        check("reached_bwd", b_pass_o, 1);
        #2 rst_i = 1'b0;
        #1;
        check("arst_b_pass", b_pass_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_epoch", epoch_o, 0);
        check("arst_w_update", w_update_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1; b_end_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("post_rst_w_update", w_update_o, 0);
            check("post_rst_busy", busy_o, 0);
        end

        for (int j = 0; j < 24; j++) begin
            cfg(1);
            run_job($urandom_range(0, 6), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1,
                    1'($urandom), 1'b1);
        end

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk_i);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
